reg_file: RTL and testbench

- Architectural register file with per-register rename tags; sits between the dispatcher and the reorder buffer's commit port.
- Dispatcher reads rs1/rs2 to obtain either a ready value or the ROB id producing it, and renames rd at issue.
- ROB commit writes retired values and releases tags; ROB clear (mispredict flush) drops all pending renames.

---
 rtl/reg_file.sv | 112 +++++++++++
 tb/tb_reg_file.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags, sitting between
// the dispatcher (rename/read) and the reorder buffer commit port.
module reg_file #(
  parameter int REG_NUM   = 32,
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 issue_en,
  input  logic [4:0]           issue_rd,
  input  logic [ROB_WIDTH-1:0] issue_rob_id,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic [31:0]          rs1_val,
  output logic                 rs1_busy,
  output logic [ROB_WIDTH-1:0] rs1_dep,
  output logic [31:0]          rs2_val,
  output logic                 rs2_busy,
  output logic [ROB_WIDTH-1:0] rs2_dep,
  input  logic                 commit_en,
  input  logic [4:0]           commit_rd,
  input  logic [31:0]          commit_val,
  input  logic [ROB_WIDTH-1:0] commit_rob_id,
  input  logic                 clear
);

  logic [31:0]          val_q  [REG_NUM];
  logic [31:0]          val_d  [REG_NUM];
  logic [ROB_WIDTH-1:0] tag_q  [REG_NUM];
  logic [ROB_WIDTH-1:0] tag_d  [REG_NUM];
  logic [REG_NUM-1:0]   busy_q;
  logic [REG_NUM-1:0]   busy_d;

  logic commit_wr;
  logic issue_wr;

  assign commit_wr = rdy && commit_en && (commit_rd != 5'd0);
  assign issue_wr  = rdy && issue_en && (issue_rd != 5'd0) && !clear;

  // Commit is applied first so that a same-cycle issue to the same register
  // overrides busy/tag while the committed value still lands in val.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (commit_wr) begin
      val_d[commit_rd] = commit_val;
      if (tag_q[commit_rd] == commit_rob_id) begin
        busy_d[commit_rd] = 1'b0;
      end
    end
    if (rdy && clear) begin
      busy_d = '0;
      for (int i = 0; i < REG_NUM; i++) begin
        tag_d[i] = '0;
      end
    end else if (issue_wr) begin
      busy_d[issue_rd] = 1'b1;
      tag_d[issue_rd]  = issue_rob_id;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the value array is reset too, because software may read any register
    // before writing it and expects zero; state uses non-blocking assignments only.
    if (!rst) begin
      val_q  <= '{default: '0};
      tag_q  <= '{default: '0};
      busy_q <= '0;
    end else begin
      val_q  <= val_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
    end
  end

  // Reads see pre-edge state plus a bypass from a matching commit in flight.
  always_comb begin
    rs1_val  = val_q[rs1];
    rs1_busy = 1'b0;
    rs1_dep  = '0;
    if (rs1 == 5'd0) begin
      rs1_val = '0;
    end else if (busy_q[rs1]) begin
      if (commit_en && (commit_rd == rs1) && (commit_rob_id == tag_q[rs1])) begin
        rs1_val = commit_val;
      end else begin
        rs1_busy = 1'b1;
        rs1_dep  = tag_q[rs1];
      end
    end
  end

  always_comb begin
    rs2_val  = val_q[rs2];
    rs2_busy = 1'b0;
    rs2_dep  = '0;
    if (rs2 == 5'd0) begin
      rs2_val = '0;
    end else if (busy_q[rs2]) begin
      if (commit_en && (commit_rd == rs2) && (commit_rob_id == tag_q[rs2])) begin
        rs2_val = commit_val;
      end else begin
        rs2_busy = 1'b1;
        rs2_dep  = tag_q[rs2];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by randomized
// traffic compared against an array-based reference model.
module tb_reg_file;

  localparam int RW = 4;

  typedef struct packed {
    logic [31:0]   val;
    logic          busy;
    logic [RW-1:0] dep;
  } rd_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy;
  logic          issue_en;
  logic [4:0]    issue_rd;
  logic [RW-1:0] issue_rob_id;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [31:0]   rs1_val;
  logic          rs1_busy;
  logic [RW-1:0] rs1_dep;
  logic [31:0]   rs2_val;
  logic          rs2_busy;
  logic [RW-1:0] rs2_dep;
  logic          commit_en;
  logic [4:0]    commit_rd;
  logic [31:0]   commit_val;
  logic [RW-1:0] commit_rob_id;
  logic          clear;

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural state as plain arrays.
  logic [31:0]   m_val  [32];
  logic          m_busy [32];
  logic [RW-1:0] m_tag  [32];

  always #5 clk = ~clk;

  reg_file #(.REG_NUM(32), .ROB_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
    .rs1(rs1), .rs2(rs2),
    .rs1_val(rs1_val), .rs1_busy(rs1_busy), .rs1_dep(rs1_dep),
    .rs2_val(rs2_val), .rs2_busy(rs2_busy), .rs2_dep(rs2_dep),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_rob_id(commit_rob_id), .clear(clear)
  );

  // Apply the architectural rules for one rising edge using the inputs present now.
  task automatic model_edge();
    bit renamed;
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
      return;
    end
    if (!rdy) return;
    renamed = issue_en && issue_rd != 0 && !clear;
    if (commit_en && commit_rd != 0) begin
      m_val[commit_rd] = commit_val;
      if (m_tag[commit_rd] == commit_rob_id && !(renamed && issue_rd == commit_rd))
        m_busy[commit_rd] = 1'b0;
    end
    if (clear) begin
      for (int i = 0; i < 32; i++) begin
        m_busy[i] = 1'b0; m_tag[i] = '0;
      end
    end else if (renamed) begin
      m_busy[issue_rd] = 1'b1;
      m_tag[issue_rd]  = issue_rob_id;
    end
  endtask

  function automatic rd_t exp_read(input logic [4:0] rs);
    rd_t r;
    r = '{val: m_val[rs], busy: 1'b0, dep: '0};
    if (rs == 0) r.val = '0;
    else if (m_busy[rs]) begin
      if (commit_en && commit_rd == rs && commit_rob_id == m_tag[rs]) r.val = commit_val;
      else begin r.busy = 1'b1; r.dep = m_tag[rs]; end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    issue_en = 1'b0; issue_rd = '0; issue_rob_id = '0;
    commit_en = 1'b0; commit_rd = '0; commit_val = '0; commit_rob_id = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0; issue_en = 1'b1; issue_rd = 5'd7; issue_rob_id = 4'd5;
    commit_en = 1'b1; commit_rd = 5'd7; commit_val = 32'h1234; commit_rob_id = 4'd0;
    tick(); tick();
    idle(); rs1 = 5'd7; rs2 = 5'd0;
    @(negedge clk);
    checks++;
    if ({rs1_val, rs1_busy, rs1_dep} !== 37'd0) begin
      failures++; $display("FAIL reset_rs1 got=%h/%b/%h exp=0/0/0", rs1_val, rs1_busy, rs1_dep);
    end
    checks++;
    if ({rs2_val, rs2_busy, rs2_dep} !== 37'd0) begin
      failures++; $display("FAIL reset_rs2 got=%h/%b/%h exp=0/0/0", rs2_val, rs2_busy, rs2_dep);
    end
  endtask

  task automatic test_issue_commit();
    idle(); issue_en = 1'b1; issue_rd = 5'd5; issue_rob_id = 4'd3;
    tick();
    idle(); rs1 = 5'd5;
    @(negedge clk);
    checks++;
    if (rs1_busy !== 1'b1 || rs1_dep !== 4'd3) begin
      failures++; $display("FAIL ic_busy got=%b/%h exp=1/3", rs1_busy, rs1_dep);
    end
    commit_en = 1'b1; commit_rd = 5'd5; commit_rob_id = 4'd3; commit_val = 32'hDEADBEEF;
    #1;
    checks++;
    if ({rs1_val, rs1_busy, rs1_dep} !== {32'hDEADBEEF, 1'b0, 4'd0}) begin
      failures++; $display("FAIL ic_bypass got=%h/%b/%h exp=deadbeef/0/0", rs1_val, rs1_busy, rs1_dep);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({rs1_val, rs1_busy, rs1_dep} !== {32'hDEADBEEF, 1'b0, 4'd0}) begin
      failures++; $display("FAIL ic_stored got=%h/%b/%h exp=deadbeef/0/0", rs1_val, rs1_busy, rs1_dep);
    end
  endtask

  task automatic test_stale_commit();
    idle(); issue_en = 1'b1; issue_rd = 5'd6; issue_rob_id = 4'd2;
    tick();
    issue_rob_id = 4'd9;
    tick();
    idle(); commit_en = 1'b1; commit_rd = 5'd6; commit_rob_id = 4'd2; commit_val = 32'h11;
    tick();
    idle(); rs1 = 5'd6;
    @(negedge clk);
    checks++;
    if ({rs1_val, rs1_busy, rs1_dep} !== {32'h11, 1'b1, 4'd9}) begin
      failures++; $display("FAIL stale_commit got=%h/%b/%h exp=11/1/9", rs1_val, rs1_busy, rs1_dep);
    end
    commit_en = 1'b1; commit_rd = 5'd6; commit_rob_id = 4'd9; commit_val = 32'h22;
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({rs1_val, rs1_busy, rs1_dep} !== {32'h22, 1'b0, 4'd0}) begin
      failures++; $display("FAIL young_commit got=%h/%b/%h exp=22/0/0", rs1_val, rs1_busy, rs1_dep);
    end
  endtask

  task automatic test_conflict();
    idle(); issue_en = 1'b1; issue_rd = 5'd8; issue_rob_id = 4'd4;
    tick();
    issue_rob_id = 4'd5;
    commit_en = 1'b1; commit_rd = 5'd8; commit_rob_id = 4'd4; commit_val = 32'hAA;
    tick();
    idle(); rs2 = 5'd8;
    @(negedge clk);
    checks++;
    if ({rs2_val, rs2_busy, rs2_dep} !== {32'hAA, 1'b1, 4'd5}) begin
      failures++; $display("FAIL same_cycle_conflict got=%h/%b/%h exp=aa/1/5", rs2_val, rs2_busy, rs2_dep);
    end
  endtask

  task automatic test_flush();
    for (int r = 1; r <= 3; r++) begin
      idle(); issue_en = 1'b1; issue_rd = 5'(r); issue_rob_id = 4'(r);
      tick();
    end
    idle(); clear = 1'b1;
    commit_en = 1'b1; commit_rd = 5'd1; commit_rob_id = 4'd1; commit_val = 32'h5;
    issue_en = 1'b1; issue_rd = 5'd4; issue_rob_id = 4'd6;
    tick();
    idle(); rs1 = 5'd1; rs2 = 5'd4;
    @(negedge clk);
    checks++;
    if ({rs1_val, rs1_busy, rs1_dep} !== {32'h5, 1'b0, 4'd0}) begin
      failures++; $display("FAIL flush_x1 got=%h/%b/%h exp=5/0/0", rs1_val, rs1_busy, rs1_dep);
    end
    checks++;
    if ({rs2_val, rs2_busy, rs2_dep} !== 37'd0) begin
      failures++; $display("FAIL flush_x4 got=%h/%b/%h exp=0/0/0", rs2_val, rs2_busy, rs2_dep);
    end
    rs1 = 5'd2; rs2 = 5'd3;
    #1;
    checks++;
    if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || rs1_dep !== 4'd0 || rs2_dep !== 4'd0) begin
      failures++; $display("FAIL flush_x2_x3 got=%b%b/%h%h exp=00/00", rs1_busy, rs2_busy, rs1_dep, rs2_dep);
    end
  endtask

  task automatic test_x0_rdy();
    idle(); issue_en = 1'b1; issue_rd = 5'd0; issue_rob_id = 4'd7;
    tick();
    idle(); commit_en = 1'b1; commit_rd = 5'd0; commit_rob_id = 4'd7; commit_val = 32'h99;
    tick();
    idle(); rs1 = 5'd0;
    @(negedge clk);
    checks++;
    if ({rs1_val, rs1_busy, rs1_dep} !== 37'd0) begin
      failures++; $display("FAIL x0_read got=%h/%b/%h exp=0/0/0", rs1_val, rs1_busy, rs1_dep);
    end
    rdy = 1'b0; issue_en = 1'b1; issue_rd = 5'd10; issue_rob_id = 4'd1;
    commit_en = 1'b1; commit_rd = 5'd11; commit_rob_id = 4'd0; commit_val = 32'h77;
    tick();
    idle(); rs1 = 5'd10; rs2 = 5'd11;
    @(negedge clk);
    checks++;
    if (rs1_busy !== 1'b0 || rs1_dep !== 4'd0) begin
      failures++; $display("FAIL rdy_low_issue got=%b/%h exp=0/0", rs1_busy, rs1_dep);
    end
    checks++;
    if (rs2_val !== 32'h0) begin
      failures++; $display("FAIL rdy_low_commit got=%h exp=0", rs2_val);
    end
  endtask

  task automatic test_random();
    rd_t e1, e2;
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 99) != 0);
      rdy       = ($urandom_range(0, 7) != 0);
      clear     = ($urandom_range(0, 24) == 0);
      issue_en  = $urandom_range(0, 1);
      issue_rd  = 5'($urandom_range(0, 7));
      issue_rob_id = 4'($urandom);
      commit_en = $urandom_range(0, 1);
      commit_rd = 5'($urandom_range(0, 7));
      commit_val = $urandom;
      commit_rob_id = $urandom_range(0, 1) ? m_tag[commit_rd] : 4'($urandom);
      rs1 = ($urandom_range(0, 3) == 0) ? commit_rd : 5'($urandom_range(0, 9));
      rs2 = 5'($urandom_range(0, 31));
      @(negedge clk);
      e1 = exp_read(rs1);
      e2 = exp_read(rs2);
      checks++;
      if (rs1_busy !== e1.busy || rs1_dep !== e1.dep || (!e1.busy && rs1_val !== e1.val)) begin
        failures++;
        $display("FAIL rand_rs1 n=%0d rs=%0d got=%h/%b/%h exp=%h/%b/%h",
                 n, rs1, rs1_val, rs1_busy, rs1_dep, e1.val, e1.busy, e1.dep);
      end
      checks++;
      if (rs2_busy !== e2.busy || rs2_dep !== e2.dep || (!e2.busy && rs2_val !== e2.val)) begin
        failures++;
        $display("FAIL rand_rs2 n=%0d rs=%0d got=%h/%b/%h exp=%h/%b/%h",
                 n, rs2, rs2_val, rs2_busy, rs2_dep, e2.val, e2.busy, e2.dep);
      end
      tick();
    end
  endtask

  initial begin
    idle();
    rs1 = '0; rs2 = '0;
    test_reset();
    test_issue_commit();
    test_stale_commit();
    test_conflict();
    test_flush();
    test_x0_rdy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
